// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared definitions for the DAC SPI receive slave.
//   dac_spi_rx_state_t  - receiver FSM states
//   DAC_DATA_WIDTH      - bits per DAC frame
//   DAC_CODE_WIDTH      - LSBs of the frame forming the DAC code
//   DAC_SPI_SYNC_STAGES - synchronizer depth on the serial pins
package dac_spi_pkg;

  localparam int DAC_DATA_WIDTH      = 24;
  localparam int DAC_CODE_WIDTH      = 16;
  localparam int DAC_SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } dac_spi_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, parameterizable width and reset value.
// Ports:
//   clk_i  in         destination clock
//   rst_i  in         synchronous, active-high reset (loads RST_VAL)
//   d_i    in  WIDTH  asynchronous inputs
//   q_o    out WIDTH  synchronized outputs
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: oversampling SPI slave receiving MSB-first DAC frames.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   synchronous, active-high reset
//   sync_i   in   frame select (active low, asynchronous)
//   sclk_i   in   serial clock (idles low, asynchronous)
//   sdi_i    in   serial data, sampled on sclk falling edge
//   data_o   out  last correctly received frame
//   code_o   out  DAC code, data_o[CODE_WIDTH-1:0]
//   valid_o  out  one-cycle pulse when data_o updates
//   err_o    out  one-cycle pulse on a frame of the wrong length
//   busy_o   out  high while a frame is being shifted in
// Optional (macro DAC_SPI_RX_STATS_EN):
//   frame_cnt_o out 16  saturating count of good frames
//   err_cnt_o   out 16  saturating count of bad frames
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int CODE_WIDTH = DAC_CODE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sync_i,
  input  logic                  sclk_i,
  input  logic                  sdi_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o
`ifdef DAC_SPI_RX_STATS_EN
  ,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           err_cnt_o
`endif
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

  // pin_s = {sync, sclk, sdi} after the synchronizer
  logic [2:0] pin_s;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b100)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({sync_i, sclk_i, sdi_i}),
    .q_o   (pin_s)
  );

  // Third stage plus registered edge pulses; sdi travels alongside so the
  // sampled bit is the one present while sclk was still high.
  logic sync_d, sclk_d, sdi_d;
  logic sync_rise_q, sync_fall_q, sclk_fall_q, sdi_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_d      <= 1'b1;
      sclk_d      <= 1'b0;
      sdi_d       <= 1'b0;
      sync_rise_q <= 1'b0;
      sync_fall_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      sync_d      <= pin_s[2];
      sclk_d      <= pin_s[1];
      sdi_d       <= pin_s[0];
      sync_rise_q <= pin_s[2] & ~sync_d;
      sync_fall_q <= ~pin_s[2] & sync_d;
      sclk_fall_q <= ~pin_s[1] & sclk_d;
      sdi_q       <= sdi_d;
    end
  end

  dac_spi_rx_state_t state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic              clr, shift, eval;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= WAIT_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // The synchronizer resets to sync=1, so a pin held low through reset only
  // shows up a couple of cycles later. WAIT_IDLE therefore needs sync high
  // for three consecutive cycles, which flushes the pipeline before IDLE.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    clr      = 1'b0;
    shift    = 1'b0;
    eval     = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (!pin_s[2]) begin
          settle_d = '0;
        end else if (settle_q == 2'd2) begin
          settle_d = '0;
          state_d  = IDLE;
        end else begin
          settle_d = settle_q + 2'd1;
        end
      end
      IDLE: begin
        if (sync_fall_q) begin
          clr     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = sclk_fall_q;
        if (sync_rise_q) begin
          eval    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  logic [CNT_W-1:0]      cnt_q, cnt_upd;
  logic [DATA_WIDTH-1:0] sr_q, sr_upd;
  logic                  good, bad;

  // A bit arriving in the same cycle as the sync rising edge is counted
  // before the frame length is judged.
  always_comb begin
    cnt_upd = cnt_q;
    sr_upd  = sr_q;
    if (shift) begin
      sr_upd = {sr_q[DATA_WIDTH-2:0], sdi_q};
      if (cnt_q != CNT_SAT) cnt_upd = cnt_q + CNT_W'(1);
    end
  end

  assign good = eval && (cnt_upd == CNT_FULL);
  assign bad  = eval && (cnt_upd != CNT_FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= good;
      err_o   <= bad;
      if (clr) begin
        cnt_q <= '0;
        sr_q  <= '0;
      end else begin
        cnt_q <= cnt_upd;
        sr_q  <= sr_upd;
      end
      if (good) data_o <= sr_upd;
    end
  end

  assign code_o = data_o[CODE_WIDTH-1:0];
  assign busy_o = (state_q == SHIFT);

`ifdef DAC_SPI_RX_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (good && frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 16'd1;
      if (bad && err_cnt_o != '1)    err_cnt_o   <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb_dac_spi_rx: self-checking bench for dac_spi_rx. A length-based frame
// model (good iff exactly DATA_WIDTH sclk falls) predicts pulses, data and,
// with DAC_SPI_RX_STATS_EN defined, the frame/error counters.
module tb_dac_spi_rx;

  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sync_i = 1'b1;
  logic          sclk_i = 1'b0;
  logic          sdi_i = 1'b0;
  logic [DW-1:0] data_o;
  logic [CW-1:0] code_o;
  logic          valid_o, err_o, busy_o;
`ifdef DAC_SPI_RX_STATS_EN
  logic [15:0]   frame_cnt_o, err_cnt_o;
`endif

  dac_spi_rx #(
    .DATA_WIDTH (DW),
    .CODE_WIDTH (CW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sync_i  (sync_i),
    .sclk_i  (sclk_i),
    .sdi_i   (sdi_i),
    .data_o  (data_o),
    .code_o  (code_o),
    .valid_o (valid_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
`ifdef DAC_SPI_RX_STATS_EN
    ,
    .frame_cnt_o (frame_cnt_o),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor
  int            cyc = 0;
  int            valid_seen = 0;
  int            err_seen = 0;
  int            last_valid_cyc = -1;
  int            last_err_cyc = -1;
  int            rise_cyc = 0;
  logic [DW-1:0] valid_q[$];

  // Reference model state
  logic [DW-1:0] exp_data = '0;
  int            exp_frames = 0;
  int            exp_errs = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (valid_o) begin
      valid_seen++;
      last_valid_cyc = cyc;
      valid_q.push_back(data_o);
    end
    if (err_o) begin
      err_seen++;
      last_err_cyc = cyc;
    end
    if (valid_o || err_o) begin
      n_checks++;
      if (valid_o && err_o) begin
        n_fail++;
        $display("FAIL excl_pulse: valid_o=%b err_o=%b required not both high", valid_o, err_o);
      end
    end
  end

  task automatic clear_mon();
    valid_seen = 0;
    err_seen   = 0;
    valid_q.delete();
  endtask

  task automatic model_reset();
    exp_data   = '0;
    exp_frames = 0;
    exp_errs   = 0;
  endtask

  task automatic frame_start(input int half);
    @(negedge clk);
    sync_i = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [63:0] w, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      sclk_i = 1'b1;
      sdi_i  = w[i];
      repeat (half) @(negedge clk);
      sclk_i = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic frame_end();
    sync_i   = 1'b1;
    sdi_i    = 1'b0;
    rise_cyc = cyc;
  endtask

  task automatic send_frame(input logic [63:0] w, input int n, input int half, input int gap);
    frame_start(half);
    clock_bits(w, n, half);
    frame_end();
    if (n == DW) begin
      exp_data = w[DW-1:0];
      exp_frames++;
    end else begin
      exp_errs++;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_mon();
    repeat (20) @(negedge clk);
    n_checks++;
    if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
    n_checks++;
    if (code_o !== '0) begin n_fail++; $display("FAIL reset_code: got %h want 0", code_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++;
    if (valid_seen != 0 || err_seen != 0 || valid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: valid=%0d err=%0d want 0/0", valid_seen, err_seen);
    end
`ifdef DAC_SPI_RX_STATS_EN
    n_checks++;
    if (frame_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: frames=%0d errs=%0d want 0/0", frame_cnt_o, err_cnt_o);
    end
`endif
  endtask

  task automatic test_frame();
    clear_mon();
    send_frame(64'h00ABCD, DW, 4, 10);
    n_checks++;
    if (valid_seen != 1 || err_seen != 0) begin
      n_fail++;
      $display("FAIL frame_pulses: valid=%0d err=%0d want 1/0", valid_seen, err_seen);
    end
    n_checks++;
    if (data_o !== 24'h00ABCD) begin n_fail++; $display("FAIL frame_data: got %h want 00abcd", data_o); end
    n_checks++;
    if (code_o !== 16'hABCD) begin n_fail++; $display("FAIL frame_code: got %h want abcd", code_o); end
    n_checks++;
    if (last_valid_cyc - rise_cyc != 4) begin
      n_fail++;
      $display("FAIL frame_latency: got %0d edges want 4", last_valid_cyc - rise_cyc);
    end
  endtask

  task automatic test_bad_len();
    clear_mon();
    send_frame({$urandom, $urandom}, DW - 1, 4, 10);
    send_frame({$urandom, $urandom}, DW + 1, 4, 10);
    n_checks++;
    if (err_seen != 2 || valid_seen != 0) begin
      n_fail++;
      $display("FAIL badlen_pulses: err=%0d valid=%0d want 2/0", err_seen, valid_seen);
    end
    n_checks++;
    if (data_o !== exp_data) begin n_fail++; $display("FAIL badlen_data: got %h want %h", data_o, exp_data); end
    n_checks++;
    if (last_err_cyc - rise_cyc != 4) begin
      n_fail++;
      $display("FAIL badlen_latency: got %0d edges want 4", last_err_cyc - rise_cyc);
    end
`ifdef DAC_SPI_RX_STATS_EN
    n_checks++;
    if (err_cnt_o !== 16'(exp_errs)) begin
      n_fail++;
      $display("FAIL badlen_errcnt: got %0d want %0d", err_cnt_o, exp_errs);
    end
`endif
  endtask

  task automatic test_wait_idle();
    @(negedge clk);
    rst    = 1'b1;
    sync_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_mon();
    clock_bits({$urandom, $urandom}, 10, 4);
    frame_end();
    repeat (10) @(negedge clk);
    n_checks++;
    if (valid_seen != 0 || err_seen != 0) begin
      n_fail++;
      $display("FAIL waitidle_pulses: valid=%0d err=%0d want 0/0", valid_seen, err_seen);
    end
    n_checks++;
    if (data_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL waitidle_state: data=%h busy=%b want 0/0", data_o, busy_o);
    end
    send_frame(64'h123456, DW, 4, 10);
    n_checks++;
    if (valid_seen != 1 || data_o !== 24'h123456) begin
      n_fail++;
      $display("FAIL waitidle_next: valid=%0d data=%h want 1/123456", valid_seen, data_o);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    frame_start(4);
    clock_bits({$urandom, $urandom}, 12, 4);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy_o); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b want 0", busy_o); end
    frame_end();
    repeat (10) @(negedge clk);
    n_checks++;
    if (valid_seen != 0 || err_seen != 0) begin
      n_fail++;
      $display("FAIL midrst_pulses: valid=%0d err=%0d want 0/0", valid_seen, err_seen);
    end
    send_frame(64'h00FFFF, DW, 4, 10);
    n_checks++;
    if (valid_seen != 1 || data_o !== 24'h00FFFF) begin
      n_fail++;
      $display("FAIL midrst_next: valid=%0d data=%h want 1/00ffff", valid_seen, data_o);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    // gap 2 + the realigning negedge in frame_start = sync high 3 cycles
    send_frame(64'h000001, DW, 4, 2);
    send_frame(64'h00FFFE, DW, 4, 10);
    n_checks++;
    if (valid_seen != 2 || err_seen != 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: valid=%0d err=%0d want 2/0", valid_seen, err_seen);
    end else begin
      n_checks++;
      if (valid_q[0] !== 24'h000001 || valid_q[1] !== 24'h00FFFE) begin
        n_fail++;
        $display("FAIL b2b_order: got %h,%h want 000001,00fffe", valid_q[0], valid_q[1]);
      end
    end
`ifdef DAC_SPI_RX_STATS_EN
    n_checks++;
    if (frame_cnt_o !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL b2b_framecnt: got %0d want %0d", frame_cnt_o, exp_frames);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int          half, len;
      logic [63:0] w;
      half = int'($urandom_range(3, 6));
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : DW;
      w    = {$urandom, $urandom};
      clear_mon();
      send_frame(w, len, half, 6);
      n_checks++;
      if (len == DW ? (valid_seen != 1 || err_seen != 0) : (err_seen != 1 || valid_seen != 0)) begin
        n_fail++;
        $display("FAIL rand_pulses[%0d]: len=%0d valid=%0d err=%0d", k, len, valid_seen, err_seen);
      end
      n_checks++;
      if (data_o !== exp_data || code_o !== exp_data[CW-1:0]) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: len=%0d got %h/%h want %h", k, len, data_o, code_o, exp_data);
      end
    end
`ifdef DAC_SPI_RX_STATS_EN
    n_checks++;
    if (frame_cnt_o !== 16'(exp_frames) || err_cnt_o !== 16'(exp_errs)) begin
      n_fail++;
      $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", frame_cnt_o, err_cnt_o, exp_frames, exp_errs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_len();
    test_wait_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
